// File: rtl/mic_pkg.sv
// rtl/mic_pkg.sv - shared state type and framing-mode constants for the stereo mic receiver
package mic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CAPTURE,
        DONE
    } mic_state_e;

    localparam int MODE_LJ  = 0;
    localparam int MODE_I2S = 1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO; a push into a full FIFO succeeds only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/mic_rx_stereo.sv
// rtl/mic_rx_stereo.sv - stereo ADC serial receiver: LRC edge detect, word capture, pair FIFO
module mic_rx_stereo
    import mic_pkg::*;
#(
    parameter int N          = 16,
    parameter int I2S_MODE   = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         bclk,
    input  logic         reset,
    input  logic         adclrc,
    input  logic         adcdat,
    input  logic         sample_ready,
    output logic         sample_valid,
    output logic [N-1:0] sample_left,
    output logic [N-1:0] sample_right,
    output logic         frame_error,
    output logic         overflow
);

    localparam int             CW       = $clog2(N + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(N - 1);

    mic_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-2:0]    shift_q, shift_d;
    logic            chan_q, chan_d;
    logic            adclrc_q;
    logic [N-1:0]    left_q;
    logic            left_ok_q;
    logic            frame_err_q;
    logic            overflow_q;

    logic            lrc_edge;
    logic            lrc_rise;
    logic [N-1:0]    word;
    logic            complete;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [2*N-1:0]  fifo_head;

    assign lrc_edge = adclrc_q ^ adclrc;
    assign lrc_rise = ~adclrc_q & adclrc;
    assign word     = {shift_q, adcdat};

    // An LRC edge always wins: it restarts capture even on the would-be LSB cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        chan_d   = chan_q;
        complete = 1'b0;
        if (lrc_edge) begin
            state_d = (I2S_MODE == MODE_I2S) ? SKIP : CAPTURE;
            cnt_d   = '0;
            chan_d  = adclrc;
        end else begin
            case (state_q)
                SKIP: state_d = CAPTURE;
                CAPTURE: begin
                    shift_d = word[N-2:0];
                    if (cnt_q == LAST_BIT) begin
                        complete = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign push = complete & ~chan_q & left_ok_q;
    assign pop  = sample_valid & sample_ready;

    always_ff @(posedge bclk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            chan_q      <= 1'b0;
            adclrc_q    <= adclrc;
            left_q      <= '0;
            left_ok_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            chan_q      <= chan_d;
            adclrc_q    <= adclrc;
            frame_err_q <= lrc_edge & ((state_q == SKIP) | (state_q == CAPTURE));
            overflow_q  <= push & fifo_full & ~pop;
            if (complete & chan_q) begin
                left_q <= word;
            end
            if (lrc_rise | push) begin
                left_ok_q <= 1'b0;
            end else if (complete & chan_q) begin
                left_ok_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (2 * N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (bclk),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({left_q, word}),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign sample_valid = ~fifo_empty;
    assign sample_left  = sample_valid ? fifo_head[2*N-1:N] : '0;
    assign sample_right = sample_valid ? fifo_head[N-1:0]   : '0;
    assign frame_error  = frame_err_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_mic_rx_stereo.sv
// tb/tb_mic_rx_stereo.sv - randomized self-checking bench for mic_rx_stereo in LJ and I2S framing
module tb_mic_rx_stereo;

    logic bclk = 1'b0;
    always #5 bclk = ~bclk;

    logic        reset;
    logic        lrc_a, dat_a, rdy_a;
    logic        lrc_b, dat_b, rdy_b, rdy_c;
    logic        val_a, fe_a, ov_a;
    logic [15:0] l_a, r_a;
    logic        val_b, fe_b, ov_b;
    logic [23:0] l_b, r_b;
    logic        val_c, fe_c, ov_c;
    logic [23:0] l_c, r_c;

    mic_rx_stereo #(.N(16), .I2S_MODE(0), .FIFO_DEPTH(4)) dut_a (
        .bclk(bclk), .reset(reset), .adclrc(lrc_a), .adcdat(dat_a), .sample_ready(rdy_a),
        .sample_valid(val_a), .sample_left(l_a), .sample_right(r_a),
        .frame_error(fe_a), .overflow(ov_a));

    mic_rx_stereo #(.N(24), .I2S_MODE(1), .FIFO_DEPTH(4)) dut_b (
        .bclk(bclk), .reset(reset), .adclrc(lrc_b), .adcdat(dat_b), .sample_ready(rdy_b),
        .sample_valid(val_b), .sample_left(l_b), .sample_right(r_b),
        .frame_error(fe_b), .overflow(ov_b));

    mic_rx_stereo #(.N(24), .I2S_MODE(0), .FIFO_DEPTH(4)) dut_c (
        .bclk(bclk), .reset(reset), .adclrc(lrc_b), .adcdat(dat_b), .sample_ready(rdy_c),
        .sample_valid(val_c), .sample_left(l_c), .sample_right(r_c),
        .frame_error(fe_c), .overflow(ov_c));

    int errors = 0;
    int checks = 0;
    int fe_a_cnt = 0, ov_a_cnt = 0, fe_b_cnt = 0, fe_c_cnt = 0;

    // Serial bits of the most recent left/right slot, indexed by BCLK position after the LRC edge.
    bit sb_l [32];
    bit sb_r [32];
    bit          tr_valid [33];
    logic [15:0] tr_l [33];
    logic [15:0] tr_r [33];
    int rdy_pulse_j = -1;

    always @(negedge bclk) begin
        if (fe_a === 1'b1) fe_a_cnt <= fe_a_cnt + 1;
        if (ov_a === 1'b1) ov_a_cnt <= ov_a_cnt + 1;
        if (fe_b === 1'b1) fe_b_cnt <= fe_b_cnt + 1;
        if (fe_c === 1'b1) fe_c_cnt <= fe_c_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input bit chan, input int off, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[30:0], chan ? sb_l[off+i] : sb_r[off+i]};
        end
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge bclk);
    endtask

    task automatic send_slot(input int line, input bit chan, input logic [31:0] w,
                             input int nw, input int off, input int len);
        for (int j = 0; j < len; j++) begin
            bit b;
            @(negedge bclk);
            tr_valid[j] = val_a;
            tr_l[j] = l_a;
            tr_r[j] = r_a;
            if (line == 0 && !chan && rdy_pulse_j >= 0) rdy_a = (j == rdy_pulse_j);
            if (j >= off && j < off + nw) b = w[nw-1-(j-off)];
            else b = 1'($urandom_range(0, 1));
            if (chan) sb_l[j] = b;
            else sb_r[j] = b;
            if (line == 0) begin
                lrc_a = chan;
                dat_a = b;
            end else begin
                lrc_b = chan;
                dat_b = b;
            end
        end
    endtask

    task automatic send_frame(input int line, input logic [31:0] l, input logic [31:0] r,
                              input int nw, input int off);
        send_slot(line, 1'b1, l, nw, off, 32);
        send_slot(line, 1'b0, r, nw, off, 32);
    endtask

    task automatic pop_pair(input int line, output bit ok, output logic [31:0] l, output logic [31:0] r);
        ok = 1'b0;
        l = '0;
        r = '0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge bclk);
            case (line)
                0: if (val_a) begin l = {16'h0, l_a}; r = {16'h0, r_a}; rdy_a = 1'b1; ok = 1'b1; end
                1: if (val_b) begin l = {8'h0, l_b};  r = {8'h0, r_b};  rdy_b = 1'b1; ok = 1'b1; end
                default: if (val_c) begin l = {8'h0, l_c}; r = {8'h0, r_c}; rdy_c = 1'b1; ok = 1'b1; end
            endcase
        end
        if (ok) begin
            @(negedge bclk);
            rdy_a = 1'b0;
            rdy_b = 1'b0;
            rdy_c = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lrc_a = 1'b0; dat_a = 1'b0; rdy_a = 1'b0;
        lrc_b = 1'b0; dat_b = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        idle(3);
        checks++; if ({val_a, fe_a, ov_a} !== 3'b000) begin errors++; $display("FAIL reset_flags_a: got %b want 000", {val_a, fe_a, ov_a}); end
        checks++; if ({l_a, r_a} !== 32'h0) begin errors++; $display("FAIL reset_data_a: got %h want 0", {l_a, r_a}); end
        checks++; if ({val_b, fe_b, ov_b, val_c, fe_c, ov_c} !== 6'b0) begin errors++; $display("FAIL reset_flags_bc: got %b want 0", {val_b, fe_b, ov_b, val_c, fe_c, ov_c}); end
        checks++; if ({l_b, r_b, l_c, r_c} !== 96'h0) begin errors++; $display("FAIL reset_data_bc: got %h want 0", {l_b, r_b, l_c, r_c}); end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_lj_basic();
        int fe0, ov0;
        logic [31:0] exp_l, exp_r;
        fe0 = fe_a_cnt; ov0 = ov_a_cnt;
        rdy_a = 1'b1;
        send_slot(0, 1'b1, 32'hA5C3, 16, 1, 32);
        exp_l = model(1'b1, 1, 16);
        send_slot(0, 1'b0, 32'h1234, 16, 1, 32);
        exp_r = model(1'b0, 1, 16);
        rdy_a = 1'b0;
        idle(3);
        checks++; if (tr_valid[16] !== 1'b0) begin errors++; $display("FAIL lj_valid_early: got %b want 0", tr_valid[16]); end
        checks++; if (tr_valid[17] !== 1'b1) begin errors++; $display("FAIL lj_valid_rise: got %b want 1", tr_valid[17]); end
        checks++; if ({16'h0, tr_l[17]} !== exp_l || exp_l !== 32'hA5C3) begin errors++; $display("FAIL lj_left: got %h want %h", tr_l[17], exp_l); end
        checks++; if ({16'h0, tr_r[17]} !== exp_r || exp_r !== 32'h1234) begin errors++; $display("FAIL lj_right: got %h want %h", tr_r[17], exp_r); end
        checks++; if (tr_valid[18] !== 1'b0) begin errors++; $display("FAIL lj_popped: got %b want 0", tr_valid[18]); end
        checks++; if (fe_a_cnt - fe0 != 0 || ov_a_cnt - ov0 != 0) begin errors++; $display("FAIL lj_no_errors: got fe=%0d ov=%0d want 0 0", fe_a_cnt - fe0, ov_a_cnt - ov0); end
    endtask

    task automatic test_lj_random();
        logic [31:0] ql [$];
        logic [31:0] qr [$];
        logic [31:0] gl, gr, el, er;
        bit ok;
        rdy_a = 1'b0;
        for (int f = 0; f < 3; f++) begin
            send_frame(0, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 1);
            ql.push_back(model(1'b1, 1, 16));
            qr.push_back(model(1'b0, 1, 16));
        end
        for (int f = 0; f < 3; f++) begin
            pop_pair(0, ok, gl, gr);
            el = ql.pop_front();
            er = qr.pop_front();
            checks++; if (!ok || gl !== el || gr !== er) begin errors++; $display("FAIL lj_random_%0d: got ok=%0d %h/%h want %h/%h", f, ok, gl, gr, el, er); end
        end
        idle(2);
        checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL lj_random_empty: got %b want 0", val_a); end
    endtask

    task automatic test_i2s();
        logic [31:0] bl [$];
        logic [31:0] br [$];
        logic [31:0] cl [$];
        logic [31:0] cr [$];
        logic [31:0] gl, gr, el, er;
        bit ok;
        int feb0;
        feb0 = fe_b_cnt;
        for (int f = 0; f < 3; f++) begin
            if (f == 0) send_frame(1, 32'h800001, 32'h7FFFFE, 24, 2);
            else send_frame(1, $urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF, 24, 2);
            bl.push_back(model(1'b1, 2, 24));
            br.push_back(model(1'b0, 2, 24));
            cl.push_back(model(1'b1, 1, 24));
            cr.push_back(model(1'b0, 1, 24));
        end
        for (int f = 0; f < 3; f++) begin
            pop_pair(1, ok, gl, gr);
            el = bl.pop_front();
            er = br.pop_front();
            checks++; if (!ok || gl !== el || gr !== er) begin errors++; $display("FAIL i2s_pair_%0d: got ok=%0d %h/%h want %h/%h", f, ok, gl, gr, el, er); end
            if (f == 0) begin
                checks++; if (gl !== 32'h800001 || gr !== 32'h7FFFFE) begin errors++; $display("FAIL i2s_exact: got %h/%h want 800001/7ffffe", gl, gr); end
            end
        end
        for (int f = 0; f < 3; f++) begin
            pop_pair(2, ok, gl, gr);
            el = cl.pop_front();
            er = cr.pop_front();
            checks++; if (!ok || gl !== el || gr !== er) begin errors++; $display("FAIL lj_on_i2s_%0d: got ok=%0d %h/%h want %h/%h", f, ok, gl, gr, el, er); end
            if (f == 0) begin
                checks++; if (gl === 32'h800001) begin errors++; $display("FAIL lj_on_i2s_shift: got %h want a shifted word", gl); end
            end
        end
        checks++; if (fe_b_cnt - feb0 != 0) begin errors++; $display("FAIL i2s_no_fe: got %0d want 0", fe_b_cnt - feb0); end
    endtask

    task automatic test_frame_error();
        int fe0;
        logic [31:0] el, er, gl, gr;
        bit ok;
        fe0 = fe_a_cnt;
        rdy_a = 1'b0;
        send_slot(0, 1'b1, $urandom & 32'hFFFF, 16, 1, 9);
        send_slot(0, 1'b0, $urandom & 32'hFFFF, 16, 1, 32);
        send_frame(0, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 1);
        el = model(1'b1, 1, 16);
        er = model(1'b0, 1, 16);
        idle(3);
        checks++; if (fe_a_cnt - fe0 != 1) begin errors++; $display("FAIL fe_pulse: got %0d pulses want 1", fe_a_cnt - fe0); end
        pop_pair(0, ok, gl, gr);
        checks++; if (!ok || gl !== el || gr !== er) begin errors++; $display("FAIL fe_recover: got ok=%0d %h/%h want %h/%h", ok, gl, gr, el, er); end
        idle(2);
        checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL fe_no_extra_pair: got %b want 0", val_a); end
    endtask

    task automatic test_overflow_and_full_push_pop();
        int ov0;
        logic [31:0] exl [7];
        logic [31:0] exr [7];
        logic [31:0] gl, gr;
        int order [4] = '{2, 3, 4, 6};
        bit ok;
        ov0 = ov_a_cnt;
        rdy_a = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            send_frame(0, 32'(f), $urandom & 32'hFFFF, 16, 1);
            exl[f] = model(1'b1, 1, 16);
            exr[f] = model(1'b0, 1, 16);
        end
        idle(3);
        checks++; if (ov_a_cnt - ov0 != 1) begin errors++; $display("FAIL ovf_pulse: got %0d want 1", ov_a_cnt - ov0); end
        checks++; if (val_a !== 1'b1 || {16'h0, l_a} !== exl[1]) begin errors++; $display("FAIL ovf_head: got v=%b %h want 1 %h", val_a, l_a, exl[1]); end
        rdy_pulse_j = 16;
        send_frame(0, 32'd6, $urandom & 32'hFFFF, 16, 1);
        exl[6] = model(1'b1, 1, 16);
        exr[6] = model(1'b0, 1, 16);
        rdy_pulse_j = -1;
        rdy_a = 1'b0;
        idle(3);
        checks++; if (ov_a_cnt - ov0 != 1) begin errors++; $display("FAIL full_push_pop_ovf: got %0d want 1", ov_a_cnt - ov0); end
        for (int k = 0; k < 4; k++) begin
            pop_pair(0, ok, gl, gr);
            checks++; if (!ok || gl !== exl[order[k]] || gr !== exr[order[k]]) begin errors++; $display("FAIL drain_%0d: got ok=%0d %h/%h want %h/%h", k, ok, gl, gr, exl[order[k]], exr[order[k]]); end
        end
        idle(2);
        checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", val_a); end
    endtask

    task automatic test_reset_mid_capture();
        int fe0;
        logic [31:0] el, er, gl, gr;
        bit ok;
        fe0 = fe_a_cnt;
        rdy_a = 1'b0;
        send_frame(0, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 1);
        send_slot(0, 1'b1, $urandom & 32'hFFFF, 16, 1, 10);
        reset = 1'b1;
        idle(2);
        checks++; if ({val_a, fe_a, ov_a, l_a, r_a} !== 35'h0) begin errors++; $display("FAIL rst_mid_outputs: got %h want 0", {val_a, fe_a, ov_a, l_a, r_a}); end
        reset = 1'b0;
        idle(3);
        send_slot(0, 1'b0, $urandom & 32'hFFFF, 16, 1, 32);
        send_frame(0, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 1);
        el = model(1'b1, 1, 16);
        er = model(1'b0, 1, 16);
        idle(3);
        checks++; if (fe_a_cnt - fe0 != 0) begin errors++; $display("FAIL rst_mid_no_fe: got %0d want 0", fe_a_cnt - fe0); end
        pop_pair(0, ok, gl, gr);
        checks++; if (!ok || gl !== el || gr !== er) begin errors++; $display("FAIL rst_mid_frame: got ok=%0d %h/%h want %h/%h", ok, gl, gr, el, er); end
        idle(2);
        checks++; if (val_a !== 1'b0) begin errors++; $display("FAIL rst_mid_single: got %b want 0", val_a); end
    endtask

    initial begin
        test_reset();
        test_lj_basic();
        test_lj_random();
        test_i2s();
        test_frame_error();
        test_overflow_and_full_push_pop();
        test_reset_mid_capture();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
